// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: match FSM, game tick, serve direction, scoring and win detection.
// Define PONG_CTRL_ATTRACT_EN to let the ball run in IDLE (attract/demo mode).
module pong_game_ctrl #(
  parameter int unsigned TICK_DIV    = 65536,
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned POINT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ui_start,
  input  logic       ui_pause,
  input  logic       player_point_i,
  input  logic       opp_point_i,
  output logic       step_o,
  output logic       ball_reset_o,
  output logic       serve_dir_o,
  output logic       paddles_en_o,
  output logic [7:0] score_o,
  output logic [2:0] state_o,
  output logic       winner_o,
  output logic       demo_o
);

  localparam int unsigned TickW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PhaseMax = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [PhaseW-1:0] ServeLast = PhaseW'(SERVE_TICKS - 1);
  localparam logic [PhaseW-1:0] PointLast = PhaseW'(POINT_TICKS - 1);
  localparam logic [3:0]        WinScore  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StServe  = 3'd1,
    StPlay   = 3'd2,
    StPoint  = 3'd3,
    StPaused = 3'd4,
    StOver   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [3:0]        p_score_q, p_score_d, o_score_q, o_score_d;
  logic              winner_q, winner_d;
  logic              serve_dir_q, serve_dir_d;
  logic              step_q, step_d;
  logic              ball_reset_q, ball_reset_d;
  logic              paddles_en_q;
  logic              start_q, pause_q, armed_q;
  logic              start_edge, pause_edge, tick;
  logic              p_only, o_only;
  logic [3:0]        p_inc, o_inc;

  // armed_q masks the first cycle after reset so a held button gives no edge.
  assign start_edge = armed_q & ui_start & ~start_q;
  assign pause_edge = armed_q & ui_pause & ~pause_q;
  assign tick       = (tick_q == TickLast);
  assign p_only     = player_point_i & ~opp_point_i;
  assign o_only     = opp_point_i & ~player_point_i;
  assign p_inc      = p_score_q + 4'd1;
  assign o_inc      = o_score_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick ? '0 : tick_q + TickW'(1);
    phase_d      = phase_q;
    p_score_d    = p_score_q;
    o_score_d    = o_score_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    step_d       = 1'b0;
    ball_reset_d = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start_edge) begin
          p_score_d    = 4'd0;
          o_score_d    = 4'd0;
          winner_d     = 1'b0;
          ball_reset_d = 1'b1;
          state_d      = StServe;
        end
`ifdef PONG_CTRL_ATTRACT_EN
        else if (state_q == StIdle) begin
          step_d = tick;
          if (player_point_i | opp_point_i) begin
            ball_reset_d = 1'b1;
            serve_dir_d  = ~serve_dir_q;
          end
        end
`endif
      end
      StServe: begin
        if (tick) phase_d = phase_q + PhaseW'(1);
        if (tick && phase_q == ServeLast) state_d = StPlay;
      end
      StPlay: begin
        if (p_only) begin
          p_score_d   = p_inc;
          serve_dir_d = 1'b1;
          if (p_inc == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b1;
          end else begin
            state_d = StPoint;
          end
        end else if (o_only) begin
          o_score_d   = o_inc;
          serve_dir_d = 1'b0;
          if (o_inc == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b0;
          end else begin
            state_d = StPoint;
          end
        end else if (player_point_i && opp_point_i) begin
          state_d = StPoint;
        end else if (pause_edge) begin
          state_d = StPaused;
        end else begin
          step_d = tick;
        end
      end
      StPoint: begin
        if (tick) phase_d = phase_q + PhaseW'(1);
        if (tick && phase_q == PointLast) begin
          ball_reset_d = 1'b1;
          state_d      = StServe;
        end
      end
      StPaused: begin
        tick_d = tick_q;
        if (pause_edge) state_d = StPlay;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      tick_d  = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      phase_q      <= '0;
      p_score_q    <= 4'd0;
      o_score_q    <= 4'd0;
      winner_q     <= 1'b0;
      serve_dir_q  <= 1'b1;
      step_q       <= 1'b0;
      ball_reset_q <= 1'b0;
      paddles_en_q <= 1'b0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      p_score_q    <= p_score_d;
      o_score_q    <= o_score_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      step_q       <= step_d;
      ball_reset_q <= ball_reset_d;
      paddles_en_q <= (state_d == StServe) || (state_d == StPlay);
      start_q      <= ui_start;
      pause_q      <= ui_pause;
      armed_q      <= 1'b1;
    end
  end

`ifdef PONG_CTRL_ATTRACT_EN
  logic demo_q;
  always_ff @(posedge clk) begin
    if (!rst_n) demo_q <= 1'b0;
    else        demo_q <= (state_d == StIdle);
  end
  assign demo_o = demo_q;
`else
  assign demo_o = 1'b0;
`endif

  assign step_o       = step_q;
  assign ball_reset_o = ball_reset_q;
  assign serve_dir_o  = serve_dir_q;
  assign paddles_en_o = paddles_en_q;
  assign score_o      = {o_score_q, p_score_q};
  assign state_o      = state_q;
  assign winner_o     = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow sequencer for the Pong datapath. Owns the match state machine (idle, serve, play, point, pause, game over), the slow physics tick, serve direction, score registers and win detection. Drives one-cycle step and ball-reset strobes into the ball/paddle physics. Consumes point events back from the physics.

## Interface
- `TICK_DIV`, 65536: clock cycles per game tick; minimum 2.
- `WIN_SCORE`, 11: points to win, range 1..15.
- `SERVE_TICKS`, 60: ticks spent in SERVE before play; minimum 1.
- `POINT_TICKS`, 30: ticks spent in POINT after a score; minimum 1.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ui_start` in 1: start button, level; rising edge is used.
- `ui_pause` in 1: pause button, level; rising edge is used.
- `player_point_i` in 1: physics pulse; player scored.
- `opp_point_i` in 1: physics pulse; opponent scored.
- `step_o` out 1: one-cycle physics advance strobe.
- `ball_reset_o` out 1: one-cycle strobe; recentre ball.
- `serve_dir_o` out 1: 1 = serve right, 0 = serve left.
- `paddles_en_o` out 1: paddle movement allowed.
- `score_o` out 8: [7:4] opponent score, [3:0] player score.
- `state_o` out 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, OVER=5.
- `winner_o` out 1: valid in OVER; 1 = player, 0 = opponent.
- `demo_o` out 1: attract mode active (0 when macro absent).

## Operation
- Edge detect: `ui_start`/`ui_pause` registered once; edge = current & ~previous. No debouncing; inputs are already synchronous.
- Tick counter: counts 0..TICK_DIV-1 and pulses an internal tick at TICK_DIV-1. Cleared on every state change. Frozen in PAUSED.
- Phase counter: counts ticks in SERVE/POINT. Cleared on state entry.
- IDLE: start edge → clear scores, pulse `ball_reset_o`, go to SERVE.
- SERVE: after SERVE_TICKS ticks → PLAY.
- PLAY: `step_o` pulses once per tick. Pause edge → PAUSED. Point handling:
  - Exactly one point input high: increment that 4-bit score, then go to POINT. If the new score equals WIN_SCORE, go to OVER instead and set `winner_o`.
  - `serve_dir_o` is set toward the side that conceded: player scored → 1; opponent scored → 0.
  - Both point inputs high in the same cycle: no score change, `serve_dir_o` unchanged, go to POINT.
- POINT: after POINT_TICKS ticks → pulse `ball_reset_o`, go to SERVE.
- PAUSED: pause edge → PLAY. Point inputs ignored.
- OVER: scores and winner held. Start edge → same action as start from IDLE.
- Ignored inputs:
  - Start edge in SERVE, PLAY, POINT or PAUSED.
  - Pause edge outside PLAY/PAUSED.
  - Point inputs outside PLAY.
- `paddles_en_o` = 1 in SERVE and PLAY only.

## Timing
- Reset values:
  - state IDLE; scores 0; counters 0.
  - `step_o`, `ball_reset_o`, `winner_o`, `demo_o` = 0.
  - `serve_dir_o` = 1; `paddles_en_o` = 0.
  - Edge registers = 0. A button held through reset does not produce an edge.
- All outputs registered.
- `step_o` is high in the cycle after the internal tick, while state is PLAY.
- State changes, score updates and `winner_o` take effect on the edge after the triggering input is sampled.
- `ball_reset_o` is high for exactly the first cycle of SERVE.
- SERVE lasts exactly SERVE_TICKS×TICK_DIV cycles. POINT lasts exactly POINT_TICKS×TICK_DIV cycles.
- PLAY → PAUSED → PLAY: the tick counter resumes at 0. There is no partial-tick carry-over.
- Score width is 4 bits. WIN_SCORE ≤ 15 guarantees no wrap.
- Reset asserted mid-operation returns everything to reset values on the next edge. No strobes are emitted during that cycle.

## Configuration
- `PONG_CTRL_ATTRACT_EN` defined:
  - IDLE emits `step_o` each tick and holds `demo_o` = 1.
  - Point inputs in IDLE pulse `ball_reset_o` one cycle later, flip `serve_dir_o`, and leave scores unchanged.
  - A start edge clears `demo_o` and behaves as normal.
- Not defined: IDLE emits no strobes, `demo_o` is tied 0, and point inputs in IDLE are ignored.

## Test plan
All scenarios use TICK_DIV=4, SERVE_TICKS=2, POINT_TICKS=1, WIN_SCORE=3.
- Reset, then start edge → `ball_reset_o` pulses once, `state_o`=1 for 8 cycles, then `state_o`=2. `step_o` then pulses every 4 cycles.
- In PLAY, pulse `player_point_i` → `score_o`=0x01, `serve_dir_o`=1, `state_o`=3 for 4 cycles. Then `ball_reset_o` pulses and `state_o`=1.
- Three opponent points → `score_o`=0x30, `state_o`=5, `winner_o`=0. Later point pulses leave the score unchanged. A start edge clears to 0x00 and enters SERVE.
- `player_point_i` and `opp_point_i` high together in PLAY → score unchanged, `serve_dir_o` unchanged, `state_o`=3.
- Pause edge in PLAY, hold 20 cycles with point pulses → no `step_o`, score unchanged. A second pause edge returns to PLAY, and `step_o` is next seen 4 cycles later.
- `rst_n`=0 for one cycle in POINT with score 0x21 → `score_o`=0x00, `state_o`=0, `serve_dir_o`=1, and no `ball_reset_o`.
